systolic_array_tile: RTL and testbench

Parametrised output-stationary systolic array with built-in input skewing, tile sequencing and a row-serial result drain. Accepts one K-step per handshake beat (a column of A and a row of B), accumulates C = A·B in a ROWS×COLS PE grid, then streams C out one row per beat. It replaces the fixed-size array plus external skewer/drain control in the matmul datapath, sitting between the unified-buffer readers and the output writeback.

---
 rtl/systolic_array_tile.sv | 229 ++++++++++++++++++++++
 tb/tb_systolic_array_tile.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_tile.sv
// Output-stationary ROWS x COLS systolic tile with input skewing, tile sequencing and row-serial drain.
// Define SYSTOLIC_SATURATE_EN to clamp accumulators on overflow instead of wrapping.
`timescale 1ns/1ps
module systolic_array_tile #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ROWS*DATA_WIDTH-1:0]    a_data,
  input  logic [COLS*DATA_WIDTH-1:0]    b_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [COLS*ACC_WIDTH-1:0]     out_data,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          acc_overflow
);

  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(ROWS + COLS);
  localparam int FLUSH_N = ROWS + COLS - 2;

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            ovf_q;
  logic            accept;
  logic            clear_acc;

  logic signed [DATA_WIDTH-1:0] a_pe  [ROWS][COLS];
  logic                         a_tag [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_pe  [ROWS][COLS];
  logic                         b_tag [ROWS][COLS];
  logic [ROWS*COLS-1:0]           ovf_vec;
  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_flat;

  function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic neg);
    return neg ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction

  // Returns {overflow, next accumulator value}.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] acc,
                                                 input logic signed [ACC_WIDTH-1:0] prod);
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        ovf;
    sum = acc + prod;
    ovf = (acc[ACC_WIDTH-1] == prod[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
`ifdef SYSTOLIC_SATURATE_EN
    if (ovf) sum = saturate(acc[ACC_WIDTH-1]);
`endif
    return {ovf, sum};
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clear_acc = 1'b0;
    case (state_q)
      IDLE, COMPUTE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_N);
          end else begin
            state_d = COMPUTE;
          end
        end
      end
      // The last operand needs ROWS+COLS-1 edges to reach the far corner PE.
      FLUSH: begin
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == RW'(ROWS-1)) begin
            row_d     = '0;
            state_d   = IDLE;
            clear_acc = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_last = (state_q == DRAIN) && (row_q == RW'(ROWS-1));
  assign out_row  = row_q;
  assign busy     = (state_q != IDLE);
  assign out_data = acc_flat[int'(row_q)*COLS*ACC_WIDTH +: COLS*ACC_WIDTH];
  assign acc_overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ovf_q <= 1'b0;
    else if (clear_acc)  ovf_q <= 1'b0;
    else if (|ovf_vec)   ovf_q <= 1'b1;
  end

  // Stage p0..pr: A element r is delayed r extra cycles before column 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [DATA_WIDTH-1:0] d_p [r+1];
    logic                         v_p [r+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= r; i++) begin
          d_p[i] <= '0;
          v_p[i] <= 1'b0;
        end
      end else begin
        d_p[0] <= accept ? a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        v_p[0] <= accept;
        for (int i = 1; i <= r; i++) begin
          d_p[i] <= d_p[i-1];
          v_p[i] <= v_p[i-1];
        end
      end
    end
    assign a_pe[r][0]  = d_p[r];
    assign a_tag[r][0] = v_p[r];
  end

  // Stage p0..pc: B element c is delayed c extra cycles before row 0.
  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [DATA_WIDTH-1:0] d_p [c+1];
    logic                         v_p [c+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= c; i++) begin
          d_p[i] <= '0;
          v_p[i] <= 1'b0;
        end
      end else begin
        d_p[0] <= accept ? b_data[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        v_p[0] <= accept;
        for (int i = 1; i <= c; i++) begin
          d_p[i] <= d_p[i-1];
          v_p[i] <= v_p[i-1];
        end
      end
    end
    assign b_pe[0][c]  = d_p[c];
    assign b_tag[0][c] = v_p[c];
  end

  // PE grid: A hops right, B hops down one PE per cycle; each PE owns one C element.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      if (c > 0) begin : g_a
        logic signed [DATA_WIDTH-1:0] a_q;
        logic                         av_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q  <= '0;
            av_q <= 1'b0;
          end else begin
            a_q  <= a_pe[r][c-1];
            av_q <= a_tag[r][c-1];
          end
        end
        assign a_pe[r][c]  = a_q;
        assign a_tag[r][c] = av_q;
      end
      if (r > 0) begin : g_b
        logic signed [DATA_WIDTH-1:0] b_q;
        logic                         bv_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            b_q  <= '0;
            bv_q <= 1'b0;
          end else begin
            b_q  <= b_pe[r-1][c];
            bv_q <= b_tag[r-1][c];
          end
        end
        assign b_pe[r][c]  = b_q;
        assign b_tag[r][c] = bv_q;
      end

      logic signed [2*DATA_WIDTH-1:0] prod_w;
      logic signed [ACC_WIDTH-1:0]    acc_q;
      logic [ACC_WIDTH:0]             add_w;
      logic                           fire;

      assign fire   = a_tag[r][c] & b_tag[r][c];
      assign prod_w = (2*DATA_WIDTH)'(a_pe[r][c]) * (2*DATA_WIDTH)'(b_pe[r][c]);
      assign add_w  = acc_add(acc_q, ACC_WIDTH'(prod_w));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         acc_q <= '0;
        else if (clear_acc) acc_q <= '0;
        else if (fire)      acc_q <= add_w[ACC_WIDTH-1:0];
      end

      assign ovf_vec[r*COLS+c] = fire & add_w[ACC_WIDTH];
      assign acc_flat[(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH] = acc_q;
    end
  end

endmodule

// File: tb/tb_systolic_array_tile.sv
// Scoreboard bench for systolic_array_tile: stimulus pushes expected C rows, a monitor pops on each result beat.
`timescale 1ns/1ps
module tb_systolic_array_tile;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int MAXK = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [ROWS*DW-1:0]      a_data;
  logic [COLS*DW-1:0]      b_data;
  logic                    in_valid, in_last, in_ready;
  logic [COLS*AW-1:0]      out_data;
  logic [$clog2(ROWS)-1:0] out_row;
  logic                    out_valid, out_last, out_ready, busy, acc_overflow;

  systolic_array_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .a_data(a_data), .b_data(b_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_row(out_row), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .acc_overflow(acc_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COLS*AW-1:0] data;
    int                 row;
    bit                 last;
    bit                 ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   A[MAXK][ROWS];
  int   B[MAXK][COLS];

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: C = A*B in k order, with per-step range handling on a signed AW-bit accumulator.
  task automatic push_expected(int K);
    longint hi = (longint'(1) <<< (AW-1)) - 1;
    longint lo = -(longint'(1) <<< (AW-1));
    longint span = longint'(1) <<< AW;
    longint acc [ROWS][COLS];
    bit     ovf = 1'b0;
    exp_t   e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        acc[r][c] = 0;
        for (int k = 0; k < K; k++) begin
          acc[r][c] += longint'(A[k][r] * B[k][c]);
          if (acc[r][c] > hi || acc[r][c] < lo) begin
            ovf = 1'b1;
`ifdef SYSTOLIC_SATURATE_EN
            acc[r][c] = (acc[r][c] > hi) ? hi : lo;
`else
            while (acc[r][c] > hi) acc[r][c] -= span;
            while (acc[r][c] < lo) acc[r][c] += span;
`endif
          end
        end
      end
    for (int r = 0; r < ROWS; r++) begin
      e.data = '0;
      for (int c = 0; c < COLS; c++) e.data[c*AW +: AW] = AW'(acc[r][c]);
      e.row  = r;
      e.last = (r == ROWS-1);
      e.ovf  = ovf;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: row %0d presented with nothing pending", out_row);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_row", longint'(out_row), longint'(mon_e.row));
        check("out_last", longint'(out_last), longint'(mon_e.last));
        check("acc_overflow", longint'(acc_overflow), longint'(mon_e.ovf));
        for (int c = 0; c < COLS; c++)
          check($sformatf("c[%0d][%0d]", mon_e.row, c),
                longint'($signed(out_data[c*AW +: AW])), longint'($signed(mon_e.data[c*AW +: AW])));
      end
    end
  end

  task automatic check_reset_state(string tag);
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_last"}, longint'(out_last), 0);
    check({tag, "_out_row"}, longint'(out_row), 0);
    check({tag, "_out_data"}, longint'(out_data), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_acc_overflow"}, longint'(acc_overflow), 0);
  endtask

  // gap < 0 picks a random 0..2 idle cycles after each beat.
  task automatic send_tile(int K, int gap, bit push);
    int n;
    int g;
    if (push) push_expected(K);
    for (int k = 0; k < K; k++) begin
      for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = DW'(A[k][r]);
      for (int c = 0; c < COLS; c++) b_data[c*DW +: DW] = DW'(B[k][c]);
      in_valid = 1'b1;
      in_last  = (k == K-1);
      n = 0;
      while (!in_ready && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      check("in_ready_wait", longint'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      a_data   = ROWS*DW'($urandom);
      b_data   = COLS*DW'($urandom);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle(bit rand_rdy);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    check("drain_complete", longint'(busy || exp_q.size() != 0), 0);
  endtask

  task automatic fill_random(int K);
    for (int k = 0; k < K; k++) begin
      for (int r = 0; r < ROWS; r++) A[k][r] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < COLS; c++) B[k][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic fill_const(int K, int av, int bv);
    for (int k = 0; k < K; k++) begin
      for (int r = 0; r < ROWS; r++) A[k][r] = av;
      for (int c = 0; c < COLS; c++) B[k][c] = bv;
    end
  endtask

  initial begin
    int n;
    logic [COLS*AW-1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    a_data = '0; b_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity A: each C row equals the matching B row; latency from in_last to first result.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < ROWS; r++) A[k][r] = (k == r) ? 1 : 0;
      for (int c = 0; c < COLS; c++) B[k][c] = k*4 + c;
    end
    send_tile(4, 0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_valid_latency", n, ROWS+COLS-1);
    wait_idle(1'b0);

    // Bubbles between beats contribute nothing: 3 * (2 * -3) = -18.
    fill_const(3, 2, -3);
    send_tile(3, 1, 1'b1);
    wait_idle(1'b0);

    // Back-pressure during row 1, with a stray in_valid that must be ignored.
    fill_random(2);
    out_ready = 1'b0;
    send_tile(2, 0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_valid_seen", longint'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    held = out_data;
    in_valid = 1'b1;
    repeat (5) begin
      check("stall_row", longint'(out_row), 1);
      check("stall_data", longint'(out_data), longint'(held));
      check("stall_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle(1'b0);

    // Back-to-back tiles: second tile must start from cleared accumulators.
    fill_const(2, 1, 1);
    send_tile(2, 0, 1'b1);
    fill_const(1, 1, 1);
    send_tile(1, 0, 1'b1);
    wait_idle(1'b0);

    // Accumulator overflow: 5 * 127 * 127 = 80645 exceeds 16-bit signed range.
    fill_const(5, 127, 127);
    send_tile(5, 0, 1'b1);
    wait_idle(1'b0);

    // Reset while flushing discards the tile; a following K=1 tile is clean.
    fill_random(2);
    send_tile(2, 0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("flush_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge clk); #1;
    check_reset_state("held_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random(1);
    send_tile(1, 0, 1'b1);
    wait_idle(1'b0);

    // Randomized tiles with random gaps and random out_ready.
    for (int t = 0; t < 10; t++) begin
      int K = int'($urandom_range(1, 6));
      fill_random(K);
      send_tile(K, -1, 1'b1);
      wait_idle(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
